// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-through capture, stall-time refresh from WB,
// and combinational MEM/WB operand forwarding into the ALU inputs.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_alu_src,
    input  logic [2:0]  id_alu_ctrl,
    input  logic        id_reg_write,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd_addr,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_result,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [2:0]  alu_ctrl,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_reg_write,
    output logic        ex_valid,
    output logic        ex_illegal
);

    localparam logic [2:0] ALU_ADD = 3'b010;

    logic [4:0]  rs_addr_q;
    logic [4:0]  rt_addr_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic        alu_src_q;

    logic        legal_code;
    logic        take_bubble;
    logic        wb_ok;
    logic        mem_ok;
    logic        wb_hit_id_rs;
    logic        wb_hit_id_rt;
    logic        wb_hit_ex_rs;
    logic        wb_hit_ex_rt;
    logic        mem_hit_ex_rs;
    logic        mem_hit_ex_rt;
    logic [31:0] op_a;
    logic [31:0] op_b;

    always_comb begin
        legal_code = 1'b0;
        case (id_alu_ctrl)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: legal_code = 1'b1;
            default:                                legal_code = 1'b0;
        endcase
    end

    // Flush outranks stall, and an invalid ID slot only matters when not stalled.
    assign take_bubble = rst | flush | (~stall & ~id_valid);

    assign wb_ok         = wb_reg_write  && (wb_rd_addr  != 5'd0);
    assign mem_ok        = mem_reg_write && (mem_rd_addr != 5'd0);
    assign wb_hit_id_rs  = wb_ok  && (wb_rd_addr  == id_rs_addr);
    assign wb_hit_id_rt  = wb_ok  && (wb_rd_addr  == id_rt_addr);
    assign wb_hit_ex_rs  = wb_ok  && (wb_rd_addr  == rs_addr_q);
    assign wb_hit_ex_rt  = wb_ok  && (wb_rd_addr  == rt_addr_q);
    assign mem_hit_ex_rs = mem_ok && (mem_rd_addr == rs_addr_q);
    assign mem_hit_ex_rt = mem_ok && (mem_rd_addr == rt_addr_q);

    always_ff @(posedge clk) begin
        if (take_bubble) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= 1'b0;
            alu_ctrl     <= ALU_ADD;
            alu_src_q    <= 1'b0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            ex_rd_addr   <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
        end else if (stall) begin
            if (wb_hit_ex_rs) rs_data_q <= wb_result;
            if (wb_hit_ex_rt) rt_data_q <= wb_result;
        end else begin
            ex_valid     <= 1'b1;
            ex_reg_write <= id_reg_write & legal_code;
            ex_illegal   <= ~legal_code;
            alu_ctrl     <= legal_code ? id_alu_ctrl : ALU_ADD;
            alu_src_q    <= id_alu_src;
            rs_addr_q    <= id_rs_addr;
            rt_addr_q    <= id_rt_addr;
            ex_rd_addr   <= id_rd_addr;
            rs_data_q    <= wb_hit_id_rs ? wb_result : id_rs_data;
            rt_data_q    <= wb_hit_id_rt ? wb_result : id_rt_data;
            imm_q        <= id_imm;
        end
    end

    always_comb begin
        op_a = rs_data_q;
        if (mem_hit_ex_rs)     op_a = mem_result;
        else if (wb_hit_ex_rs) op_a = wb_result;
        op_b = rt_data_q;
        if (mem_hit_ex_rt)     op_b = mem_result;
        else if (wb_hit_ex_rt) op_b = wb_result;
    end

    assign alu_op1       = op_a;
    assign alu_op2       = alu_src_q ? imm_q : op_b;
    assign ex_store_data = op_b;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  the decode stage presents a real instruction.
REQ-005 stall  input  1  hold the EX register contents.
REQ-006 flush  input  1  load a bubble into the EX register.
REQ-007 id_rs_data, id_rt_data, id_imm  input  32 each  register-file reads and the sign-extended immediate.
REQ-008 id_rs_addr, id_rt_addr, id_rd_addr  input  5 each  source and destination register numbers.
REQ-009 id_alu_src  input  1  operand-2 select: 0 selects rt, 1 selects immediate.
REQ-010 id_alu_ctrl  input  3  ALU operation code.
REQ-011 id_reg_write  input  1  the instruction writes its destination register.
REQ-012 mem_reg_write  input  1, mem_rd_addr  input  5, mem_result  input  32  forwarding source from the MEM stage.
REQ-013 wb_reg_write  input  1, wb_rd_addr  input  5, wb_result  input  32  forwarding source from the WB stage.
REQ-014 alu_op1, alu_op2  output  32 each  operands driven to the ALU.
REQ-015 alu_ctrl  output  3  ALU control.
REQ-016 ex_store_data  output  32  forwarded rt value, used for stores.
REQ-017 ex_rd_addr  output  5; ex_reg_write  output  1; ex_valid  output  1; ex_illegal  output  1  flags an unsupported ALU code.

Function
REQ-018 EX register update priority per rising edge SHALL be: rst, then flush, then stall, then load.
REQ-019 Bubble contents SHALL be:
- ex_valid=0, ex_reg_write=0, ex_illegal=0;
- alu_ctrl=3'b010;
- all address and data fields 0;
- alu_src=0.
REQ-020 A load SHALL occur when no higher-priority condition is active; it captures all id_* fields, with ex_valid=id_valid.
REQ-021 A load with id_valid=0 SHALL capture a bubble.
REQ-022 Legal ALU codes SHALL be 000 (and), 001 (or), 010 (add), 110 (sub) and 111 (slt).
REQ-023 A load of a code outside the legal set with id_valid=1 SHALL:
- capture alu_ctrl=3'b010 and ex_reg_write=0;
- set ex_illegal=1 for that instruction only.
REQ-024 Write-through at load: if wb_reg_write=1, wb_rd_addr!=0 and wb_rd_addr equals id_rs_addr (or id_rt_addr), the block SHALL capture wb_result instead of id_rs_data (or id_rt_data).
REQ-025 Refresh during stall (stall=1, flush=0): all fields SHALL be held, except that a held rs or rt data field is overwritten with wb_result when wb_reg_write=1, wb_rd_addr!=0 and wb_rd_addr matches the held address.
REQ-026 Forwarding SHALL be combinational from the registered EX fields and the current MEM/WB inputs.
REQ-027 Operand A SHALL be selected as follows:
- mem_result if mem_reg_write=1, mem_rd_addr!=0 and mem_rd_addr equals ex rs address;
- else wb_result under the same rule applied to WB;
- else the registered rs data.
REQ-028 Operand B (forwarded rt) SHALL use the same rule as REQ-027 applied to the rt address, with MEM priority over WB.
REQ-029 Outputs SHALL be driven as: alu_op1=operand A; alu_op2 = registered imm when alu_src=1, else operand B; ex_store_data = operand B always.
REQ-030 Register 0 SHALL never be forwarded or written through; the registered value passes unchanged.
REQ-031 Forwarding SHALL apply to bubbles as well, since their addresses are 0 and therefore never match.
REQ-032 Latency SHALL be one clock from the ID inputs to the EX outputs; there is zero added latency on the forwarding path.
REQ-033 Simultaneous flush and stall SHALL insert a bubble.
REQ-034 Simultaneous stall and WB match SHALL apply the refresh of REQ-025.

Reset
REQ-035 When rst=1 at a rising edge, the EX register SHALL load the bubble of REQ-019, regardless of stall and flush.
REQ-036 After reset, alu_op1=0, alu_op2=0, alu_ctrl=3'b010, ex_store_data=0, ex_rd_addr=0, ex_reg_write=0, ex_valid=0 and ex_illegal=0, provided the MEM/WB write enables are 0.
REQ-037 A reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-038 Basic load: load rs_data=5, rt_data=7, alu_ctrl=110, alu_src=0 -> next cycle alu_op1=5, alu_op2=7, alu_ctrl=110, ex_valid=1.
REQ-039 Forward priority: EX rs=3; mem_rd=3 with mem_result=0xAA; wb_rd=3 with wb_result=0xBB; both write enables 1 -> alu_op1=0xAA. Drop mem_reg_write -> alu_op1=0xBB.
REQ-040 Register 0: EX rs=0 with mem_rd=0, mem_reg_write=1, mem_result=0x55 -> alu_op1 equals registered rs data (0).
REQ-041 Immediate and store data: alu_src=1, imm=0xFFFFFFFC, rt forwarded from MEM =0x10 -> alu_op2=0xFFFFFFFC, ex_store_data=0x10.
REQ-042 Stall and flush: stall 2 cycles with a WB write to the held rt=4 (wb_result=0x99) -> outputs held, rt field becomes 0x99. Then flush=1 together with stall=1 -> bubble, ex_valid=0.
REQ-043 Illegal code: load alu_ctrl=100 with id_valid=1, id_reg_write=1 -> alu_ctrl=010, ex_reg_write=0, ex_illegal=1; ex_illegal clears on the next load.
